// File: rtl/controle_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: FSM state
// encodings, opcode and branch funct3 constants, and ALU operation codes.
package controle_pkg;

  // State encodings are visible on the estado bus, so the values are fixed.
  typedef enum logic [3:0] {
    StBusca      = 4'b0000,
    StDecod      = 4'b0001,
    StExecR      = 4'b0010,
    StExecI      = 4'b0011,
    StEndereco   = 4'b0100,
    StMemLe      = 4'b0101,
    StMemEscreve = 4'b0110,
    StEscrita    = 4'b0111,
    StDesvio     = 4'b1000,
    StFim        = 4'b1110,
    StInvalido   = 4'b1111
  } estado_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

endpackage

// File: rtl/contador_instrucoes.sv
// 32-bit retired-instruction counter. Only compiled when
// UNIDADECONTROLE_CONTADOR_EN is defined, since it is instantiated only then.
// Ports:
//   clk        - clock
//   reset_n    - asynchronous active-low reset, clears the count
//   incrementa - count one retired instruction on this edge
//   contagem   - current count, wraps from 0xFFFFFFFF to 0
`ifdef UNIDADECONTROLE_CONTADOR_EN
module contador_instrucoes (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        incrementa,
  output logic [31:0] contagem
);

  logic [31:0] contagem_q, contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (incrementa) begin
      contagem_d = contagem_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign contagem = contagem_q;

endmodule
`endif

// File: rtl/unidadecontrole.sv
// Multi-cycle control FSM for the RISC-V datapath. Sequences fetch, decode,
// execute, memory and write-back phases, one per cycle, and drives the datapath
// enables as Moore outputs of the registered state (plus the held instruction).
// Optional feature macro: UNIDADECONTROLE_CONTADOR_EN builds the retire counter;
// without it instrucoes_concluidas is tied to 0.
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   pc                    - current word-indexed PC
//   instrucao             - instruction latched by fetch
//   zero                  - ALU zero flag, used in the branch state
//   estado                - registered FSM state
//   pc_escreve/pc_seleciona, reg_escreve, mem_le/mem_escreve, mem_para_reg,
//   ula_fonte, ula_op     - datapath controls
//   parado                - execution ended (FIM) or trapped (INVALIDO)
//   instrucoes_concluidas - retired-instruction count
module unidadecontrole
  import controle_pkg::*;
#(
  parameter int unsigned NUM_INSTR = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic [31:0] instrucao,
  input  logic        zero,
  output logic [3:0]  estado,
  output logic        pc_escreve,
  output logic        pc_seleciona,
  output logic        reg_escreve,
  output logic        mem_le,
  output logic        mem_escreve,
  output logic        mem_para_reg,
  output logic        ula_fonte,
  output logic [1:0]  ula_op,
  output logic        parado,
  output logic [31:0] instrucoes_concluidas
);

  estado_e estado_q, estado_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instrucao;

  assign opcode           = instrucao[6:0];
  assign funct3           = instrucao[14:12];
  assign unused_instrucao = ^{instrucao[31:15], instrucao[11:7]};

  // Next-state logic. instrucao is not looked at in BUSCA: fetch is still
  // latching it on that edge.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StBusca: begin
        estado_d = (pc >= 32'(NUM_INSTR)) ? StFim : StDecod;
      end
      StDecod: begin
        unique case (opcode)
          OP_R:              estado_d = StExecR;
          OP_I:              estado_d = StExecI;
          OP_LOAD, OP_STORE: estado_d = StEndereco;
          OP_BRANCH: begin
            // Only beq/bne are implemented; other branches trap here.
            estado_d = (funct3 == F3_BEQ || funct3 == F3_BNE) ? StDesvio : StInvalido;
          end
          default:           estado_d = StInvalido;
        endcase
      end
      StExecR, StExecI: estado_d = StEscrita;
      StEndereco:       estado_d = (opcode == OP_LOAD) ? StMemLe : StMemEscreve;
      StMemLe:          estado_d = StEscrita;
      StEscrita, StMemEscreve, StDesvio: estado_d = StBusca;
      StFim:            estado_d = StFim;
      StInvalido:       estado_d = StInvalido;
      default:          estado_d = StInvalido;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= StBusca;
    end else begin
      estado_q <= estado_d;
    end
  end

  assign estado = estado_q;

  // Output decode. Reset forces StBusca, whose outputs are all 0, so no
  // enable can be high while reset_n is low.
  always_comb begin
    pc_escreve   = 1'b0;
    pc_seleciona = 1'b0;
    reg_escreve  = 1'b0;
    mem_le       = 1'b0;
    mem_escreve  = 1'b0;
    mem_para_reg = 1'b0;
    ula_fonte    = 1'b0;
    ula_op       = ULA_ADD;
    parado       = 1'b0;
    unique case (estado_q)
      StExecR: begin
        ula_op = ULA_FUNCT;
      end
      StExecI: begin
        ula_op    = ULA_FUNCT;
        ula_fonte = 1'b1;
      end
      StEndereco: begin
        ula_op    = ULA_ADD;
        ula_fonte = 1'b1;
      end
      StMemLe: begin
        mem_le = 1'b1;
      end
      StMemEscreve: begin
        mem_escreve = 1'b1;
        pc_escreve  = 1'b1;
      end
      StEscrita: begin
        reg_escreve  = 1'b1;
        pc_escreve   = 1'b1;
        mem_para_reg = (opcode == OP_LOAD);
      end
      StDesvio: begin
        ula_op       = ULA_SUB;
        pc_escreve   = 1'b1;
        // beq takes the branch on equal, bne on not-equal.
        pc_seleciona = (funct3 == F3_BNE) ? ~zero : zero;
      end
      StFim, StInvalido: begin
        parado = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef UNIDADECONTROLE_CONTADOR_EN
  logic retira;

  // An instruction retires on the edge that leaves its final state.
  assign retira = (estado_q == StEscrita) || (estado_q == StMemEscreve) ||
                  (estado_q == StDesvio);

  contador_instrucoes u_contador (
    .clk        (clk),
    .reset_n    (reset_n),
    .incrementa (retira),
    .contagem   (instrucoes_concluidas)
  );
`else
  assign instrucoes_concluidas = '0;
`endif

endmodule

// File: tb/tb_unidadecontrole.sv
// Directed, self-checking bench for unidadecontrole. Expected per-cycle rows
// (state, control vector, retire count) are queued before each instruction is
// driven and popped as the DUT steps through it.
module tb_unidadecontrole;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] instrucao;
  logic        zero;
  logic [3:0]  estado;
  logic        pc_escreve, pc_seleciona, reg_escreve, mem_le, mem_escreve;
  logic        mem_para_reg, ula_fonte, parado;
  logic [1:0]  ula_op;
  logic [31:0] instrucoes_concluidas;

  int vectors;
  int miscompares;
  int unsigned retired;

  unidadecontrole #(.NUM_INSTR(15)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .pc                    (pc),
    .instrucao             (instrucao),
    .zero                  (zero),
    .estado                (estado),
    .pc_escreve            (pc_escreve),
    .pc_seleciona          (pc_seleciona),
    .reg_escreve           (reg_escreve),
    .mem_le                (mem_le),
    .mem_escreve           (mem_escreve),
    .mem_para_reg          (mem_para_reg),
    .ula_fonte             (ula_fonte),
    .ula_op                (ula_op),
    .parado                (parado),
    .instrucoes_concluidas (instrucoes_concluidas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector: {pc_escreve, pc_seleciona, reg_escreve, mem_le, mem_escreve,
  //                  mem_para_reg, ula_fonte, ula_op[1:0], parado}
  localparam logic [9:0] C_NONE   = 10'b00_0000_0000;
  localparam logic [9:0] C_EXEC_R = 10'b00_0000_0100;
  localparam logic [9:0] C_EXEC_I = 10'b00_0000_1100;
  localparam logic [9:0] C_ENDER  = 10'b00_0000_1000;
  localparam logic [9:0] C_MEM_LE = 10'b00_0100_0000;
  localparam logic [9:0] C_MEM_ES = 10'b10_0010_0000;
  localparam logic [9:0] C_ESC    = 10'b10_1000_0000;
  localparam logic [9:0] C_ESC_LD = 10'b10_1001_0000;
  localparam logic [9:0] C_DES_NT = 10'b10_0000_0010;
  localparam logic [9:0] C_DES_T  = 10'b11_0000_0010;
  localparam logic [9:0] C_PARADO = 10'b00_0000_0001;

  typedef struct packed {
    logic [3:0]  st;
    logic [9:0]  ctl;
    logic [31:0] cnt;
  } row_t;

  row_t sb[$];

  function automatic logic [31:0] exp_cnt(input int unsigned r);
`ifdef UNIDADECONTROLE_CONTADOR_EN
    return r;
`else
    return 32'd0;
`endif
  endfunction

  task automatic push(input logic [3:0] st, input logic [9:0] ctl);
    row_t r;
    r.st  = st;
    r.ctl = ctl;
    r.cnt = exp_cnt(retired);
    sb.push_back(r);
  endtask

  task automatic check_row(input string tag);
    row_t r;
    logic [9:0] ctl;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL %s scoreboard empty: got %0d rows want >0", tag, sb.size());
    end
    if (sb.size() > 0) begin
      r   = sb.pop_front();
      ctl = {pc_escreve, pc_seleciona, reg_escreve, mem_le, mem_escreve,
             mem_para_reg, ula_fonte, ula_op, parado};
      vectors++;
      assert (estado === r.st) else begin
        miscompares++;
        $error("FAIL %s estado: got %b want %b", tag, estado, r.st);
      end
      vectors++;
      assert (ctl === r.ctl) else begin
        miscompares++;
        $error("FAIL %s controls: got %b want %b", tag, ctl, r.ctl);
      end
      vectors++;
      assert (instrucoes_concluidas === r.cnt) else begin
        miscompares++;
        $error("FAIL %s counter: got %0d want %0d", tag, instrucoes_concluidas, r.cnt);
      end
    end
  endtask

  // Called at a negedge while in BUSCA; checks n queued rows, one per cycle,
  // and leaves the bench at the negedge following the last one.
  task automatic run_instr(input string tag, input logic [31:0] p,
                           input logic [31:0] ins, input logic z, input int n);
    pc        = p;
    instrucao = ins;
    zero      = z;
    for (int i = 0; i < n; i++) begin
      check_row(tag);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse(input string tag);
    reset_n = 1'b0;
    #1;
    retired = 0;
    push(4'b0000, C_NONE);
    check_row(tag);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    retired     = 0;
    reset_n     = 1'b0;
    pc          = '0;
    instrucao   = '0;
    zero        = 1'b0;

    @(negedge clk);
    push(4'b0000, C_NONE);
    check_row("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // add x3,x1,x2
    push(4'b0000, C_NONE); push(4'b0001, C_NONE);
    push(4'b0010, C_EXEC_R); push(4'b0111, C_ESC);
    run_instr("add", 32'd0, 32'h002081B3, 1'b0, 4);
    retired++;

    // lw x2,0(x1)
    push(4'b0000, C_NONE); push(4'b0001, C_NONE); push(4'b0100, C_ENDER);
    push(4'b0101, C_MEM_LE); push(4'b0111, C_ESC_LD);
    run_instr("lw", 32'd1, 32'h0000A103, 1'b0, 5);
    retired++;

    // sw x2,0(x1)
    push(4'b0000, C_NONE); push(4'b0001, C_NONE);
    push(4'b0100, C_ENDER); push(4'b0110, C_MEM_ES);
    run_instr("sw", 32'd2, 32'h0020A023, 1'b0, 4);
    retired++;

    // addi x1,x1,1
    push(4'b0000, C_NONE); push(4'b0001, C_NONE);
    push(4'b0011, C_EXEC_I); push(4'b0111, C_ESC);
    run_instr("addi", 32'd3, 32'h00108093, 1'b0, 4);
    retired++;

    push(4'b0000, C_NONE); push(4'b0001, C_NONE); push(4'b1000, C_DES_T);
    run_instr("beq_z1", 32'd4, 32'h00208463, 1'b1, 3);
    retired++;

    push(4'b0000, C_NONE); push(4'b0001, C_NONE); push(4'b1000, C_DES_NT);
    run_instr("beq_z0", 32'd5, 32'h00208463, 1'b0, 3);
    retired++;

    push(4'b0000, C_NONE); push(4'b0001, C_NONE); push(4'b1000, C_DES_T);
    run_instr("bne_z0", 32'd6, 32'h00209463, 1'b0, 3);
    retired++;

    push(4'b0000, C_NONE); push(4'b0001, C_NONE); push(4'b1000, C_DES_NT);
    run_instr("bne_z1", 32'd7, 32'h00209463, 1'b1, 3);
    retired++;

    // Unsupported branch funct3 traps and stays trapped.
    push(4'b0000, C_NONE); push(4'b0001, C_NONE);
    for (int i = 0; i < 11; i++) push(4'b1111, C_PARADO);
    run_instr("br_f3", 32'd8, 32'h0020A463, 1'b0, 13);
    reset_pulse("reset_from_invalido");

    // Reset asserted mid-EXEC_R abandons the instruction.
    push(4'b0000, C_NONE); push(4'b0001, C_NONE); push(4'b0010, C_EXEC_R);
    run_instr("add_pre_rst", 32'd0, 32'h002081B3, 1'b0, 2);
    check_row("add_exec_r");
    reset_pulse("reset_mid_exec");

    // Undefined opcode.
    push(4'b0000, C_NONE); push(4'b0001, C_NONE);
    for (int i = 0; i < 11; i++) push(4'b1111, C_PARADO);
    run_instr("bad_op", 32'd0, 32'h0000007F, 1'b0, 13);
    reset_pulse("reset_from_bad_op");

    // One instruction so the frozen count is non-trivial, then run off the end.
    push(4'b0000, C_NONE); push(4'b0001, C_NONE);
    push(4'b0010, C_EXEC_R); push(4'b0111, C_ESC);
    run_instr("add2", 32'd14, 32'h002081B3, 1'b0, 4);
    retired++;

    push(4'b0000, C_NONE);
    for (int i = 0; i < 5; i++) push(4'b1110, C_PARADO);
    run_instr("fim", 32'd15, 32'h002081B3, 1'b0, 6);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL leftover rows: got %0d want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidadecontrole.md
# unidadecontrole

Multi-cycle control FSM for the RISC-V datapath. Drives the 4-bit `estado` bus consumed by the instruction-fetch stage, which latches `instrucao` on the clock edge where `estado == 4'b0000`. Decodes the latched instruction and sequences PC, register-file, ALU and data-memory enables one phase per cycle. Sits directly upstream of fetch and owns the instruction lifecycle from fetch to PC update.

## Interface
- `NUM_INSTR`, default 15: number of words in instruction memory. A PC at or beyond this value ends execution.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pc` input 32: current word-indexed PC from the PC register.
- `instrucao` input 32: latched instruction from fetch; stable outside `BUSCA`.
- `zero` input 1: ALU zero flag, valid in `DESVIO`.
- `estado` output 4: current FSM state (registered).
- `pc_escreve` output 1: PC write enable.
- `pc_seleciona` output 1: PC source select; 0 = PC+1, 1 = branch target.
- `reg_escreve` output 1: register-file write enable.
- `mem_le` output 1: data-memory read enable.
- `mem_escreve` output 1: data-memory write enable.
- `mem_para_reg` output 1: write-back source select; 1 = memory, 0 = ALU.
- `ula_fonte` output 1: ALU operand B select; 1 = immediate.
- `ula_op` output 2: ALU operation. 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `parado` output 1: high in `FIM` or `INVALIDO`.
- `instrucoes_concluidas` output 32: retired-instruction count (see Configuration).

## Operation
State encodings:
- `BUSCA` 0000, `DECOD` 0001, `EXEC_R` 0010, `EXEC_I` 0011
- `ENDERECO` 0100, `MEM_LE` 0101, `MEM_ESCREVE` 0110, `ESCRITA` 0111
- `DESVIO` 1000, `FIM` 1110, `INVALIDO` 1111

Transitions:
- `BUSCA`: goes to `FIM` if `pc >= NUM_INSTR`, else to `DECOD`.
- `DECOD`: branches on opcode `instrucao[6:0]`.
  - 0110011 → `EXEC_R`
  - 0010011 → `EXEC_I`
  - 0000011 or 0100011 → `ENDERECO`
  - 1100011 → `DESVIO`
  - any other opcode → `INVALIDO`
- `EXEC_R` and `EXEC_I` → `ESCRITA`.
- `ENDERECO`: load → `MEM_LE`; store → `MEM_ESCREVE`.
- `MEM_LE` → `ESCRITA`.
- `ESCRITA`, `MEM_ESCREVE` and `DESVIO` → `BUSCA`. These are the final states of an instruction.
- Branch funct3 other than 000 or 001 → `INVALIDO` (decided in `DECOD`).
- `FIM` and `INVALIDO` are absorbing; only `reset_n` leaves them.

Instruction lengths: R/I-type and store take 4 cycles, load takes 5, branch takes 3.

Outputs are Moore-decoded from `estado` and the held `instrucao`. The one exception is `pc_seleciona` in `DESVIO`, which also depends on `zero`. Every output not listed for a state is 0.
- `EXEC_R`: `ula_op=10`
- `EXEC_I`: `ula_op=10`, `ula_fonte=1`
- `ENDERECO`: `ula_op=00`, `ula_fonte=1`
- `MEM_LE`: `mem_le=1`
- `MEM_ESCREVE`: `mem_escreve=1`, `pc_escreve=1`
- `ESCRITA`: `reg_escreve=1`, `pc_escreve=1`; `mem_para_reg=1` only when the opcode is a load
- `DESVIO`: `ula_op=01`, `pc_escreve=1`
  - beq (funct3 000): `pc_seleciona = zero`
  - bne (funct3 001): `pc_seleciona = ~zero`

## Timing
- Reset (asynchronous, effective immediately):
  - `estado = BUSCA` (0000).
  - Every enable, `ula_op` and `parado` are 0.
  - `instrucoes_concluidas = 0`.
- Fetch is in flight on the first edge after reset release.
- Reset mid-instruction abandons the instruction. No enable may glitch high during the reset assertion.
- `pc_escreve` is asserted exactly once per retired instruction, in its final state. The PC updates on the edge leaving that state, so the next `BUSCA` sees the new PC.
- `instrucao` is sampled only in `DECOD` and later states, never in `BUSCA`.
- `mem_le` and `mem_escreve` are never asserted together.

## Configuration
- `UNIDADECONTROLE_CONTADOR_EN` defined:
  - `instrucoes_concluidas` increments by 1 on every edge leaving `ESCRITA`, `MEM_ESCREVE` or `DESVIO`.
  - Wraps from 0xFFFFFFFF to 0.
  - Holds its value in `FIM` and `INVALIDO`.
- Undefined: the port still exists and is tied to 0; no counter register is built.

## Structure
- Shared package `controle_pkg` holds:
  - the state encodings;
  - the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - the funct3 constants for beq/bne;
  - the `ula_op` codes.
- One natural sub-module, `contador_instrucoes`: the 32-bit retire counter. It is instantiated only under the macro.

## Test plan
- Reset: hold `reset_n=0` mid-`EXEC_R` → `estado=0000` asynchronously, all enables 0, counter 0.
- add x3,x1,x2 (`0x002081B3`), pc=0 → `estado` runs 0000, 0001, 0010, 0111, 0000. `reg_escreve` and `pc_escreve` are high only in 0111. Counter reads 1.
- lw x2,0(x1) (`0x0000A103`) → states 0000, 0001, 0100, 0101, 0111. `ula_fonte=1` in 0100, `mem_le=1` in 0101, `mem_para_reg=1` in 0111.
- beq x1,x2,8 (`0x00208463`):
  - `zero=1` → `DESVIO` with `pc_escreve=1`, `pc_seleciona=1`.
  - repeat with `zero=0` → `pc_seleciona=0`.
  - either case returns to 0000 after 3 cycles.
- Opcode `0x0000007F` → 1111 with `parado=1`; held for 10 cycles with no enables. Pulsing `reset_n` low returns to 0000.
- `pc=15`, `NUM_INSTR=15` in `BUSCA` → 1110 next edge, `parado=1`, counter frozen.
